// File: rtl/prio_enc_serialiser.sv
// Priority-encoder serialiser: captures an N-bit request vector, then emits the index
// of each set bit, one per accepted beat, in fixed (MSB-first) or round-robin order.
module prio_enc_serialiser #(
    parameter  int N    = 8,
    parameter  int MODE = 0,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout,
    output logic         out_last
);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] sel;
    logic         found;
    int           idx;

    // Index selection. With ptr_q = 0 after reset the round-robin search starts at
    // N-1, so both modes agree until the first grant.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++)
                if (pending_q[i]) sel = W'(i);
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = (int'(ptr_q) + N - k) % N;
                if (!found && pending_q[idx]) begin
                    sel   = W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SERVE);
    assign dout      = sel;
    // Exactly one bit left means this beat drains the vector.
    assign out_last  = (state_q == SERVE) && (pending_q != '0) &&
                       ((pending_q & (pending_q - 1'b1)) == '0);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (in_valid && (din != '0)) begin
                    pending_d = din;
                    state_d   = SERVE;
                end
            end
            SERVE: begin
                if (out_ready) begin
                    pending_d[sel] = 1'b0;
                    if (MODE != 0) ptr_d = sel;
                    if (out_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
        end
    end

endmodule

// File: tb/tb_prio_enc_serialiser.sv
// Directed bench: fixed-priority N=8, round-robin N=8 and fixed-priority N=16 instances.
module tb_prio_enc_serialiser;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        av, ar, a_irdy, a_ov, a_ol;
    logic [7:0]  ad;
    logic [2:0]  a_do;
    logic        bv, br, b_irdy, b_ov, b_ol;
    logic [7:0]  bd;
    logic [2:0]  b_do;
    logic        cv, cr, c_irdy, c_ov, c_ol;
    logic [15:0] cd;
    logic [3:0]  c_do;

    prio_enc_serialiser #(.N(8), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(av), .in_ready(a_irdy), .din(ad),
        .out_valid(a_ov), .out_ready(ar), .dout(a_do), .out_last(a_ol));
    prio_enc_serialiser #(.N(8), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(bv), .in_ready(b_irdy), .din(bd),
        .out_valid(b_ov), .out_ready(br), .dout(b_do), .out_last(b_ol));
    prio_enc_serialiser #(.N(16), .MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(cv), .in_ready(c_irdy), .din(cd),
        .out_valid(c_ov), .out_ready(cr), .dout(c_do), .out_last(c_ol));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] v);
        av = 1'b1; ad = v;
        @(negedge clk);
        av = 1'b0; ad = '0;
    endtask

    task automatic send_b(input logic [7:0] v);
        bv = 1'b1; bd = v;
        @(negedge clk);
        bv = 1'b0; bd = '0;
    endtask

    task automatic send_c(input logic [15:0] v);
        cv = 1'b1; cd = v;
        @(negedge clk);
        cv = 1'b0; cd = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        av = 0; ar = 0; ad = '0;
        bv = 0; br = 0; bd = '0;
        cv = 0; cr = 0; cd = '0;
        repeat (2) @(negedge clk);
        chk("rst_a_ov",   32'(a_ov),   0);
        chk("rst_a_do",   32'(a_do),   0);
        chk("rst_a_ol",   32'(a_ol),   0);
        chk("rst_a_irdy", 32'(a_irdy), 1);
        chk("rst_b_ov",   32'(b_ov),   0);
        chk("rst_c_ov",   32'(c_ov),   0);
        rst_n = 1'b1;
        @(negedge clk);

        // single-bit vectors, MSB then LSB
        ar = 1'b1;
        send_a(8'b1000_0000);
        chk("t1_ov",   32'(a_ov),   1);
        chk("t1_do",   32'(a_do),   7);
        chk("t1_ol",   32'(a_ol),   1);
        chk("t1_irdy", 32'(a_irdy), 0);
        @(negedge clk);
        chk("t1_bubble_ov",   32'(a_ov),   0);
        chk("t1_bubble_irdy", 32'(a_irdy), 1);
        send_a(8'b0000_0001);
        chk("t1b_do", 32'(a_do), 0);
        chk("t1b_ol", 32'(a_ol), 1);
        @(negedge clk);
        chk("t1b_idle", 32'(a_ov), 0);

        // four beats back to back
        send_a(8'b1010_0101);
        chk("t2_do7", 32'(a_do), 7);
        chk("t2_ol7", 32'(a_ol), 0);
        @(negedge clk);
        chk("t2_do5", 32'(a_do), 5);
        chk("t2_ol5", 32'(a_ol), 0);
        @(negedge clk);
        chk("t2_do2", 32'(a_do), 2);
        @(negedge clk);
        chk("t2_do0", 32'(a_do), 0);
        chk("t2_ol0", 32'(a_ol), 1);
        @(negedge clk);
        chk("t2_idle_ov",   32'(a_ov),   0);
        chk("t2_idle_irdy", 32'(a_irdy), 1);

        // backpressure for 3 cycles, with a new vector offered meanwhile
        ar = 1'b0;
        send_a(8'b0100_0010);
        chk("t3_hold0_do", 32'(a_do), 6);
        chk("t3_hold0_ol", 32'(a_ol), 0);
        av = 1'b1; ad = 8'hFF;
        @(negedge clk);
        chk("t3_hold1_do",   32'(a_do),   6);
        chk("t3_hold1_ov",   32'(a_ov),   1);
        chk("t3_hold1_irdy", 32'(a_irdy), 0);
        @(negedge clk);
        chk("t3_hold2_do", 32'(a_do), 6);
        av = 1'b0; ad = '0; ar = 1'b1;
        @(negedge clk);
        chk("t3_do1", 32'(a_do), 1);
        chk("t3_ol1", 32'(a_ol), 1);
        @(negedge clk);
        chk("t3_idle", 32'(a_ov), 0);

        // all-zero vector is accepted and dropped
        av = 1'b1; ad = 8'h00;
        @(negedge clk);
        chk("t4_irdy", 32'(a_irdy), 1);
        chk("t4_ov",   32'(a_ov),   0);
        av = 1'b0;
        @(negedge clk);
        chk("t4_ov2", 32'(a_ov), 0);

        // round-robin: grant 4, then search from 3 finds 2, then wraps to 7
        br = 1'b1;
        send_b(8'b0001_0000);
        chk("t5_do4", 32'(b_do), 4);
        chk("t5_ol4", 32'(b_ol), 1);
        @(negedge clk);
        chk("t5_idle", 32'(b_ov), 0);
        send_b(8'b1000_0100);
        chk("t5_do2", 32'(b_do), 2);
        chk("t5_ol2", 32'(b_ol), 0);
        @(negedge clk);
        chk("t5_do7", 32'(b_do), 7);
        chk("t5_ol7", 32'(b_ol), 1);
        @(negedge clk);
        chk("t5_idle2", 32'(b_ov), 0);

        // reset mid-serve; ptr was 7, so search starts at 6
        br = 1'b0;
        send_b(8'b1111_0000);
        chk("t6_do6", 32'(b_do), 6);
        br = 1'b1;
        @(negedge clk);
        chk("t6_do5", 32'(b_do), 5);
        chk("t6_ol5", 32'(b_ol), 0);
        br = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_ov",   32'(b_ov),   0);
        chk("t6_rst_irdy", 32'(b_irdy), 1);
        chk("t6_rst_do",   32'(b_do),   0);
        @(negedge clk);
        rst_n = 1'b1;
        br = 1'b1;
        // ptr cleared: search restarts at 7 rather than below the old grant
        send_b(8'b1000_0100);
        chk("t6_ptr_do7", 32'(b_do), 7);
        chk("t6_ptr_ol7", 32'(b_ol), 0);
        @(negedge clk);
        chk("t6_ptr_do2", 32'(b_do), 2);
        chk("t6_ptr_ol2", 32'(b_ol), 1);
        @(negedge clk);
        send_b(8'b0000_0010);
        chk("t6_do1", 32'(b_do), 1);
        chk("t6_ol1", 32'(b_ol), 1);
        @(negedge clk);
        chk("t6_idle", 32'(b_ov), 0);

        // 16-bit width
        cr = 1'b1;
        send_c(16'h8001);
        chk("t7_do15", 32'(c_do), 15);
        chk("t7_ol15", 32'(c_ol), 0);
        @(negedge clk);
        chk("t7_do0", 32'(c_do), 0);
        chk("t7_ol0", 32'(c_ol), 1);
        @(negedge clk);
        chk("t7_idle_ov",   32'(c_ov),   0);
        chk("t7_idle_irdy", 32'(c_irdy), 1);
        send_c(16'h0400);
        chk("t7_do10", 32'(c_do), 10);
        chk("t7_ol10", 32'(c_ol), 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
